// File: rtl/rst_seq_pkg.sv
// Shared types and width helpers for the reset-release sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } rst_seq_state_t;

  // One extra bit so the counter can hold the value n itself.
  function automatic int seq_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Reset-deassertion synchroniser: a chain of DEPTH flops that fills with ones.
module rst_sync_chain #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic sync_ok
);

  logic [DEPTH-1:0] s_q, s_d;

  always_comb begin
    s_d = clr ? '0 : {s_q[DEPTH-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) s_q <= '0;
    else        s_q <= s_d;
  end

  assign sync_ok = s_q[DEPTH-1];

endmodule

// File: rtl/rst_release_seq.sv
// Releases CH downstream resets one at a time, STAGGER cycles apart, once the
// board reset deassertion has passed through the synchroniser chain.
module rst_release_seq
  import rst_seq_pkg::*;
#(
  parameter int CH      = 4,
  parameter int DEPTH   = 2,
  parameter int STAGGER = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          soft_req,
  input  logic          hold,
  output logic [CH-1:0] q,
  output logic          done,
  output logic          busy
);

  localparam int CW = seq_w(STAGGER);
  localparam int IW = seq_w(CH);
  localparam logic [CW-1:0] CNT_LAST = CW'(STAGGER - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(CH - 1);

  rst_seq_state_t  state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d, idx_nxt;
  logic [CH-1:0]   q_q, q_d;
  logic            done_q, done_d;
  logic            sync_ok;

  rst_sync_chain #(.DEPTH(DEPTH)) u_sync (
    .clk     (clk),
    .reset   (reset),
    .clr     (soft_req),
    .sync_ok (sync_ok)
  );

  assign idx_nxt = idx_q + IW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    q_d     = q_q;
    done_d  = done_q;
    if (soft_req) begin
      // Restart wins over hold and over any release scheduled this edge.
      state_d = ST_SYNC;
      cnt_d   = '0;
      idx_d   = '0;
      q_d     = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_SYNC: begin
          if (sync_ok && !hold) begin
            q_d[0]  = 1'b1;
            cnt_d   = '0;
            state_d = (CH == 1) ? ST_DONE : ST_RELEASE;
            done_d  = (CH == 1);
          end
        end
        ST_RELEASE: begin
          if (!hold) begin
            if (cnt_q == CNT_LAST) begin
              for (int i = 0; i < CH; i++) begin
                if (IW'(i) == idx_nxt) q_d[i] = 1'b1;
              end
              idx_d = idx_nxt;
              cnt_d = '0;
              if (idx_nxt == IDX_LAST) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        ST_DONE: ;
        default: state_d = ST_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_SYNC;
      cnt_q   <= '0;
      idx_q   <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign done = done_q;
  assign busy = ~done_q;

endmodule
